writeback_stage: RTL and testbench

//  MEM/WB pipeline register plus writeback select, directly upstream of register_file.

---
 rtl/writeback_stage_pkg.sv | 16 +
 rtl/writeback_stage_if.sv | 34 +++
 rtl/writeback_stage_load_align.sv | 37 +++
 rtl/writeback_stage.sv | 103 ++++++++++
 tb/tb_writeback_stage.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared writeback-stage types: writeback source select and load funct3 codes.
package rv_wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM->WB handshake/payload plus the register-file, bypass and retire-count outputs.
interface writeback_stage_if #(
  parameter int DWIDTH   = 32,
  parameter int CNTWIDTH = 64
);
  logic                valid;
  logic                stall;
  logic                flush;
  logic [4:0]          rd;
  logic                regwren;
  logic [1:0]          wbsel;
  logic [DWIDTH-1:0]   alu;
  logic [DWIDTH-1:0]   memdata;
  logic [DWIDTH-1:0]   pc;
  logic [2:0]          funct3;

  logic [4:0]          wb_rd;
  logic [DWIDTH-1:0]   wb_data;
  logic                wb_regwren;
  logic                byp_valid;
  logic [4:0]          byp_rd;
  logic [DWIDTH-1:0]   byp_data;
  logic [CNTWIDTH-1:0] retired;

  modport master (
    output valid, stall, flush, rd, regwren, wbsel, alu, memdata, pc, funct3,
    input  wb_rd, wb_data, wb_regwren, byp_valid, byp_rd, byp_data, retired
  );

  modport slave (
    input  valid, stall, flush, rd, regwren, wbsel, alu, memdata, pc, funct3,
    output wb_rd, wb_data, wb_regwren, byp_valid, byp_rd, byp_data, retired
  );
endinterface

// File: rtl/writeback_stage_load_align.sv
// Combinational load formatter: picks byte/half from the raw word and extends it.
module load_align
  import rv_wb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (off)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = 8'h00;
    endcase
    // off[0] is ignored for halfwords; misaligned halves read the containing half
    half_sel = off[1] ? word[31:16] : word[15:0];

    data = 32'h0;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   data = word;
      F3_LBU:  data = {24'h0, byte_sel};
      F3_LHU:  data = {16'h0, half_sel};
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, writeback select, single-write guard and retire counter.
module writeback_stage
  import rv_wb_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int CNTWIDTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  writeback_stage_if.slave  bus
);

  logic                valid_q;
  logic                written_q;
  logic [4:0]          rd_q;
  logic                regwren_q;
  logic [1:0]          wbsel_q;
  logic [DWIDTH-1:0]   alu_q;
  logic [DWIDTH-1:0]   memdata_q;
  logic [DWIDTH-1:0]   pc_q;
  logic [2:0]          funct3_q;
  logic [CNTWIDTH-1:0] retired_q;

  logic [31:0]         load_data;
  logic [DWIDTH-1:0]   data_sel;
  logic                byp_live;
  logic                sel_ok;
  logic                wren_out;

  load_align u_load_align (
    .word   (memdata_q[31:0]),
    .off    (alu_q[1:0]),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      written_q <= 1'b0;
      rd_q      <= '0;
      regwren_q <= 1'b0;
      wbsel_q   <= '0;
      alu_q     <= '0;
      memdata_q <= '0;
      pc_q      <= '0;
      funct3_q  <= '0;
      retired_q <= '0;
    end else begin
      if (!bus.stall) begin
        if (bus.flush) begin
          valid_q <= 1'b0;
        end else begin
          valid_q   <= bus.valid;
          rd_q      <= bus.rd;
          regwren_q <= bus.regwren;
          wbsel_q   <= bus.wbsel;
          alu_q     <= bus.alu;
          memdata_q <= bus.memdata;
          pc_q      <= bus.pc;
          funct3_q  <= bus.funct3;
        end
      end

      // Remember a write already issued while stalled so it is not repeated
      if (bus.stall) begin
        written_q <= written_q | wren_out;
      end else begin
        written_q <= 1'b0;
      end

      if (valid_q && !bus.stall) begin
        retired_q <= retired_q + CNTWIDTH'(1);
      end
    end
  end

  always_comb begin
    data_sel = '0;
    sel_ok   = 1'b1;
    case (wbsel_q)
      WB_ALU:  data_sel = alu_q;
      WB_MEM:  data_sel = DWIDTH'(load_data);
      WB_PC4:  data_sel = pc_q + DWIDTH'(4);
      default: begin
        data_sel = '0;
        sel_ok   = 1'b0;
      end
    endcase
  end

  assign byp_live = valid_q & regwren_q & (rd_q != 5'd0);
  assign wren_out = byp_live & ~written_q & sel_ok;

  assign bus.wb_rd      = rd_q;
  assign bus.wb_data    = data_sel;
  assign bus.wb_regwren = wren_out;
  assign bus.byp_valid  = byp_live;
  assign bus.byp_rd     = rd_q;
  assign bus.byp_data   = data_sel;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed vector bench for writeback_stage: load formats, select, stall/flush, reset.
module tb_writeback_stage;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [63:0] exp_ret;

  localparam logic [31:0] MEMWORD = 32'h80F1_7F82;

  writeback_stage_if #(.DWIDTH(32), .CNTWIDTH(64)) bus ();

  writeback_stage #(.DWIDTH(32), .CNTWIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        flush;
    logic [4:0]  rd;
    logic        regwren;
    logic [1:0]  wbsel;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [2:0]  funct3;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_wren;
    logic        e_byp;
    logic [63:0] e_ret;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic st, input logic fl, input logic [4:0] rd,
                       input logic wr, input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [2:0] f3);
    bus.valid   = v;
    bus.stall   = st;
    bus.flush   = fl;
    bus.rd      = rd;
    bus.regwren = wr;
    bus.wbsel   = sel;
    bus.alu     = alu;
    bus.pc      = pc;
    bus.funct3  = f3;
    bus.memdata = MEMWORD;
  endtask

  task automatic chk_out(input string tag, input logic [4:0] rd, input logic [31:0] data,
                         input logic wren, input logic byp, input logic [63:0] ret);
    chk({tag, " rd"},       64'(bus.wb_rd),      64'(rd));
    chk({tag, " data"},     64'(bus.wb_data),    64'(data));
    chk({tag, " wren"},     64'(bus.wb_regwren), 64'(wren));
    chk({tag, " byp"},      64'(bus.byp_valid),  64'(byp));
    chk({tag, " byp_rd"},   64'(bus.byp_rd),     64'(rd));
    chk({tag, " byp_data"}, 64'(bus.byp_data),   64'(data));
    chk({tag, " retired"},  bus.retired,         ret);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    //          valid fl rd wr sel   alu           pc            f3      e_rd e_data        wr byp ret
    tbl[0]  = '{1'b1,1'b0,5'd5, 1'b1,2'd0,32'h1234,    32'h0,        3'b000, 5'd5, 32'h0000_1234,1'b1,1'b1,64'd0};
    tbl[1]  = '{1'b1,1'b0,5'd1, 1'b1,2'd1,32'h0,       32'h0,        3'b000, 5'd1, 32'hFFFF_FF82,1'b1,1'b1,64'd1};
    tbl[2]  = '{1'b1,1'b0,5'd2, 1'b1,2'd1,32'h3,       32'h0,        3'b100, 5'd2, 32'h0000_0080,1'b1,1'b1,64'd2};
    tbl[3]  = '{1'b1,1'b0,5'd3, 1'b1,2'd1,32'h2,       32'h0,        3'b001, 5'd3, 32'hFFFF_80F1,1'b1,1'b1,64'd3};
    tbl[4]  = '{1'b1,1'b0,5'd4, 1'b1,2'd1,32'h1,       32'h0,        3'b101, 5'd4, 32'h0000_7F82,1'b1,1'b1,64'd4};
    tbl[5]  = '{1'b1,1'b0,5'd6, 1'b1,2'd1,32'h2,       32'h0,        3'b010, 5'd6, 32'h80F1_7F82,1'b1,1'b1,64'd5};
    tbl[6]  = '{1'b1,1'b0,5'd8, 1'b1,2'd1,32'h1,       32'h0,        3'b000, 5'd8, 32'h0000_007F,1'b1,1'b1,64'd6};
    tbl[7]  = '{1'b1,1'b0,5'd9, 1'b1,2'd1,32'h0,       32'h0,        3'b011, 5'd9, 32'h0000_0000,1'b1,1'b1,64'd7};
    tbl[8]  = '{1'b1,1'b0,5'd10,1'b1,2'd2,32'h0,       32'hFFFF_FFFC,3'b000, 5'd10,32'h0000_0000,1'b1,1'b1,64'd8};
    tbl[9]  = '{1'b1,1'b0,5'd11,1'b1,2'd2,32'h0,       32'h0000_0100,3'b000, 5'd11,32'h0000_0104,1'b1,1'b1,64'd9};
    tbl[10] = '{1'b1,1'b0,5'd0, 1'b1,2'd0,32'hAB,      32'h0,        3'b000, 5'd0, 32'h0000_00AB,1'b0,1'b0,64'd10};
    tbl[11] = '{1'b1,1'b0,5'd12,1'b1,2'd3,32'h55,      32'h0,        3'b000, 5'd12,32'h0000_0000,1'b0,1'b1,64'd11};
    tbl[12] = '{1'b1,1'b0,5'd13,1'b0,2'd0,32'h77,      32'h0,        3'b000, 5'd13,32'h0000_0077,1'b0,1'b0,64'd12};
    tbl[13] = '{1'b0,1'b0,5'd14,1'b1,2'd0,32'h99,      32'h0,        3'b000, 5'd14,32'h0000_0099,1'b0,1'b0,64'd13};
    tbl[14] = '{1'b1,1'b1,5'd15,1'b1,2'd0,32'h66,      32'h0,        3'b000, 5'd14,32'h0000_0099,1'b0,1'b0,64'd13};
    tbl[15] = '{1'b1,1'b0,5'd16,1'b1,2'd0,32'h42,      32'h0,        3'b000, 5'd16,32'h0000_0042,1'b1,1'b1,64'd13};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 3'b000);
    #2;
    chk_out("reset", 5'd0, 32'h0, 1'b0, 1'b0, 64'd0);
    #5;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].valid, 1'b0, tbl[i].flush, tbl[i].rd, tbl[i].regwren, tbl[i].wbsel,
            tbl[i].alu, tbl[i].pc, tbl[i].funct3);
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].e_rd, tbl[i].e_data, tbl[i].e_wren,
              tbl[i].e_byp, tbl[i].e_ret);
    end

    // Stall on a rd=7 write: one write, bypass held, counted once on release
    exp_ret = 64'd14;
    drive(1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 2'd0, 32'h700, 32'h0, 3'b000);
    step();
    chk_out("stall c0", 5'd7, 32'h700, 1'b1, 1'b1, exp_ret);
    drive(1'b1, 1'b1, 1'b0, 5'd20, 1'b1, 2'd0, 32'h2000, 32'h0, 3'b000);
    step();
    chk_out("stall c1", 5'd7, 32'h700, 1'b0, 1'b1, exp_ret);
    step();
    chk_out("stall c2", 5'd7, 32'h700, 1'b0, 1'b1, exp_ret);
    bus.stall = 1'b0;
    step();
    exp_ret = exp_ret + 64'd1;
    chk_out("stall rel", 5'd20, 32'h2000, 1'b1, 1'b1, exp_ret);

    // Stall with flush keeps the held instruction; flush alone then kills it
    drive(1'b1, 1'b1, 1'b1, 5'd21, 1'b1, 2'd0, 32'h2100, 32'h0, 3'b000);
    step();
    chk_out("stall+flush", 5'd20, 32'h2000, 1'b0, 1'b1, exp_ret);
    bus.stall = 1'b0;
    step();
    exp_ret = exp_ret + 64'd1;
    chk_out("flush", 5'd20, 32'h2000, 1'b0, 1'b0, exp_ret);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 3'b000);
    step();
    chk_out("bubble", 5'd0, 32'h0, 1'b0, 1'b0, exp_ret);

    // Reset asserted mid-stall drops the held write asynchronously
    drive(1'b1, 1'b0, 1'b0, 5'd22, 1'b1, 2'd0, 32'h2200, 32'h0, 3'b000);
    step();
    chk_out("pre-rst", 5'd22, 32'h2200, 1'b1, 1'b1, exp_ret);
    bus.stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async rst", 5'd0, 32'h0, 1'b0, 1'b0, 64'd0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 3'b000);
    #2;
    rst_n = 1'b1;
    step();
    chk_out("post-rst", 5'd0, 32'h0, 1'b0, 1'b0, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
